// File: rtl/note_spi_pkg.sv
// Shared constants and types for the note SPI transmitter and receiver.
package note_spi_pkg;

    localparam int TUNE_W     = 16;
    localparam int VOL_W      = 8;
    localparam int FRAME_BITS = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [TUNE_W-1:0] tw,
        input logic [VOL_W-1:0]  vol
    );
        return {tw, vol};
    endfunction

endpackage

// File: rtl/note_spi_tx_if.sv
// Request handshake between a note producer and the SPI transmitter.
interface note_spi_tx_if;
    import note_spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [TUNE_W-1:0] tune_word;
    logic [VOL_W-1:0]  volume;

    modport master (
        output req_valid,
        output tune_word,
        output volume,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  tune_word,
        input  volume,
        output req_ready
    );

endinterface

// File: rtl/note_spi_rx.sv
// SPI receiver: rebuilds tune word and volume from complete 24-bit frames.
module note_spi_rx
    import note_spi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_i,
    input  logic              sck_i,
    input  logic              sdo_i,
    output logic [TUNE_W-1:0] tune_word_o,
    output logic [VOL_W-1:0]  volume_o,
    output logic              valid_o
);

    logic                  sck_p_q, cs_p_q, valid_q;
    logic [FRAME_BITS-1:0] sh_q;
    logic [4:0]            cnt_q;
    logic [TUNE_W-1:0]     tune_q;
    logic [VOL_W-1:0]      vol_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_p_q <= 1'b0;
            cs_p_q  <= 1'b0;
            valid_q <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            tune_q  <= '0;
            vol_q   <= '0;
        end else begin
            sck_p_q <= sck_i;
            cs_p_q  <= cs_i;
            valid_q <= 1'b0;
            if (cs_i && sck_i && !sck_p_q) begin
                sh_q  <= {sh_q[FRAME_BITS-2:0], sdo_i};
                cnt_q <= cnt_q + 5'd1;
            end
            // Truncated frames are dropped rather than published.
            if (cs_p_q && !cs_i) begin
                cnt_q <= '0;
                if (cnt_q == 5'(FRAME_BITS)) begin
                    tune_q  <= sh_q[FRAME_BITS-1:VOL_W];
                    vol_q   <= sh_q[VOL_W-1:0];
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign tune_word_o = tune_q;
    assign volume_o    = vol_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/note_spi_tx_phase_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module spi_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/note_spi_tx.sv
// Serialises {tune_word, volume} as a 24-bit SPI frame, MSB first.
module note_spi_tx
    import note_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic          clk,
    input  logic          reset,
    note_spi_tx_if.slave  req,
    output logic          cs,
    output logic          sck,
    output logic          sdo,
    output logic          busy,
    output logic          done
);

    localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
    localparam logic [4:0] LAST_BIT  = 5'(FRAME_BITS - 1);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [4:0]            bit_q, bit_d;
    logic                  cs_q, cs_d;
    logic                  sck_q, sck_d;
    logic                  done_q, done_d;
    logic                  ld;
    logic [CW-1:0]         ld_val;
    logic                  tc;
    logic                  accept;

    spi_phase_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ld),
        .load_val_i (ld_val),
        .tc_o       (tc)
    );

    assign accept = req.req_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        done_d  = 1'b0;
        ld      = 1'b0;
        ld_val  = DIV_LD;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    sh_d    = pack_frame(req.tune_word, req.volume);
                    bit_d   = '0;
                    cs_d    = 1'b1;
                    sck_d   = 1'b0;
                    ld      = 1'b1;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (tc) begin
                    state_d = ST_HIGH;
                    sck_d   = 1'b1;
                    ld      = 1'b1;
                end
            end
            ST_HIGH: begin
                // Zeros shift in, so sdo reads 0 once the last bit leaves.
                if (tc) begin
                    sck_d   = 1'b0;
                    sh_d    = {sh_q[FRAME_BITS-2:0], 1'b0};
                    ld      = 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                        bit_d   = 5'(FRAME_BITS);
                    end else begin
                        state_d = ST_LOW;
                        bit_d   = bit_q + 5'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (tc) begin
                    state_d = ST_GAP;
                    cs_d    = 1'b0;
                    done_d  = 1'b1;
                    ld      = 1'b1;
                    ld_val  = GAP_LD;
                end
            end
            ST_GAP: begin
                if (tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            done_q  <= done_d;
        end
    end

    assign req.req_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign cs            = cs_q;
    assign sck           = sck_q;
    assign sdo           = sh_q[FRAME_BITS-1];
    assign done          = done_q;

endmodule

// File: doc/note_spi_tx.md
NOTE_SPI_TX -- requirements
Module: note_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCK half-period (legal ≥1).
REQ-002 SHALL have parameter GAP_CYCLES, default 8: clk cycles CS stays low between frames (legal ≥1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request to send one frame.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port tune_word  input  16  frequency tuning word, sampled on accept.
REQ-008 SHALL have port volume  input  8  unsigned volume, sampled on accept.
REQ-009 SHALL have port cs  output  1  chip select, active-high, high for the whole frame.
REQ-010 SHALL have port sck  output  1  serial clock, idle low; receiver samples on rising edge.
REQ-011 SHALL have port sdo  output  1  serial data, MSB first.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when cs falls at frame end.

Function
REQ-014 Frame SHALL be 24 bits: {tune_word[15:0], volume[7:0]}, bit 23 first.
REQ-015 Handshake: accept when req_valid && req_ready on a clk edge; req_ready SHALL be 1 only in IDLE (decoded from state).
REQ-016 On accept, the 24-bit word SHALL load a shift register; later input changes have no effect on the frame in flight.
REQ-017 States: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
REQ-018 IDLE->SETUP on accept; cs=1, sck=0, sdo=bit 23 from the next cycle (latency 1).
REQ-019 SETUP lasts CLK_DIV cycles, then HIGH.
REQ-020 HIGH: sck=1 for CLK_DIV cycles; sdo stable throughout.
REQ-021 After HIGH, if fewer than 24 bits sent -> LOW; if 24th bit sent -> HOLD.
REQ-022 LOW: sck=0, sdo advances to next bit on the same edge sck falls, lasts CLK_DIV cycles, then HIGH.
REQ-023 HOLD: sck=0, cs=1, sdo=0, CLK_DIV cycles, then GAP.
REQ-024 GAP: cs=0, sck=0, sdo=0 for GAP_CYCLES cycles, then IDLE; done=1 in the first GAP cycle only.
REQ-025 cs SHALL be high exactly 49*CLK_DIV cycles per frame, with exactly 24 sck rising edges.
REQ-026 Bit counter SHALL be 5 bits and terminal at 24; phase counter SHALL be sized to CLK_DIV/GAP_CYCLES with no wrap.
REQ-027 cs, sck, sdo, done SHALL be registered outputs (glitch-free).
REQ-028 req_valid held high across frames SHALL yield back-to-back frames separated by exactly GAP_CYCLES+1 cs-low cycles (GAP plus one IDLE).

Reset
REQ-029 reset SHALL force IDLE, with cs=0, sck=0, sdo=0, done=0, busy=0 and req_ready=1 on the next cycle.
REQ-030 reset mid-frame SHALL abort the frame with no done pulse; a request asserted during reset SHALL NOT be accepted.
REQ-031 Reset SHALL clear the shift register, the bit counter and the phase counter.

Structure
REQ-032 Package note_spi_pkg SHALL hold FRAME_BITS=24, TUNE_W=16, VOL_W=8 and the state enum type.
REQ-033 The receiver-side module SHALL import the same package constants.
REQ-034 One sub-module, spi_phase_timer (loadable down-counter with terminal-count flag), SHALL time the SETUP, HIGH, LOW, HOLD and GAP phases.

Verification
REQ-035 Bench SHALL cover: tune_word=0x1234, volume=0x80, CLK_DIV=4 -> bits sampled at sck rising edges = 0x123480, cs high 196 cycles, one done pulse.
REQ-036 Bench SHALL cover: 0xFFFF/0xFF then 0x0000/0x00 back-to-back -> 0xFFFFFF then 0x000000, with exactly 9 cs-low cycles between frames.
REQ-037 Bench SHALL cover: inputs changed to 0xAAAA/0x55 mid-frame -> frame still 0x123480 and req_ready=0 throughout.
REQ-038 Bench SHALL cover: reset after the 10th sck rise -> cs, sck, sdo = 0 next cycle, req_ready=1, no done pulse.
REQ-039 Bench SHALL cover: CLK_DIV=1, GAP_CYCLES=1, 0xBEEF/0x42 -> 0xBEEF42, cs high 49 cycles.
REQ-040 A loopback check against the receiver SHALL show tuneWord=0x1234 and volume=0x80 after the first frame.
